// File: rtl/arith_driver_0.sv
// rtl/arith_driver_0.sv - LFSR-driven self-test harness for an external signed 8+8 adder
// Issues pseudo-random operand pairs, tracks expected sums through a LATENCY-deep line, counts mismatches.
module arith_driver_0 #(
    parameter int LATENCY = 1
) (
    input  logic       system1000,
    input  logic       system1000_rst,
    input  logic       start_i,
    input  logic [7:0] count_i,
    input  logic [7:0] seed_i,
    input  logic [8:0] result_i,
    output logic [7:0] op_a_o,
    output logic [7:0] op_b_o,
    output logic       busy_o,
    output logic       done_o,
    output logic [7:0] err_count_o,
    output logic [7:0] first_err_o
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [2:0] DRAIN_LAST = 3'(LATENCY - 1);

    state_t             state_q, state_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic [7:0]         count_q, count_d;
    logic [7:0]         idx_q, idx_d;
    logic [7:0]         err_q, err_d;
    logic [7:0]         first_q, first_d;
    logic [2:0]         drain_q, drain_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [LATENCY-1:0] vld_q, vld_d;
    logic [7:0]         lidx_q [LATENCY];
    logic [7:0]         lidx_d [LATENCY];
    logic [8:0]         lexp_q [LATENCY];
    logic [8:0]         lexp_d [LATENCY];

    logic               run;
    logic [15:0]        lfsr_next;
    logic [8:0]         exp_now;

    assign run         = (state_q == RUN);
    assign op_a_o      = run ? lfsr_q[7:0]  : 8'h00;
    assign op_b_o      = run ? lfsr_q[15:8] : 8'h00;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_count_o = err_q;
    assign first_err_o = first_q;

    always_comb begin
        lfsr_next = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);
        exp_now   = {op_a_o[7], op_a_o} + {op_b_o[7], op_b_o};

        state_d = state_q;
        lfsr_d  = lfsr_q;
        count_d = count_q;
        idx_d   = idx_q;
        err_d   = err_q;
        first_d = first_q;
        drain_d = drain_q;

        // Every cycle shifts the line; only RUN cycles insert a valid entry.
        vld_d[0]  = run;
        lidx_d[0] = idx_q;
        lexp_d[0] = exp_now;
        for (int i = 1; i < LATENCY; i++) begin
            vld_d[i]  = vld_q[i-1];
            lidx_d[i] = lidx_q[i-1];
            lexp_d[i] = lexp_q[i-1];
        end

        if (vld_q[LATENCY-1] && (result_i != lexp_q[LATENCY-1])) begin
            if (err_q != 8'hFF) begin
                err_d = err_q + 8'd1;
            end
            if (first_q == 8'hFF) begin
                first_d = lidx_q[LATENCY-1];
            end
        end

        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    count_d = count_i;
                    lfsr_d  = {seed_i, 8'hA5};
                    err_d   = 8'h00;
                    first_d = 8'hFF;
                    idx_d   = 8'h00;
                    vld_d   = '0;
                    state_d = (count_i == 8'h00) ? DONE : RUN;
                end
            end
            RUN: begin
                lfsr_d = lfsr_next;
                idx_d  = idx_q + 8'd1;
                if (idx_q == count_q - 8'd1) begin
                    state_d = DRAIN;
                    drain_d = 3'd0;
                end
            end
            DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = DONE;
                end else begin
                    drain_d = drain_q + 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN) || (state_d == DRAIN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge system1000 or posedge system1000_rst) begin
        if (system1000_rst) begin
            state_q <= IDLE;
            lfsr_q  <= 16'h00A5;
            count_q <= 8'h00;
            idx_q   <= 8'h00;
            err_q   <= 8'h00;
            first_q <= 8'hFF;
            drain_q <= 3'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            vld_q   <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                lidx_q[i] <= 8'h00;
                lexp_q[i] <= 9'h000;
            end
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            first_q <= first_d;
            drain_q <= drain_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            vld_q   <= vld_d;
            for (int i = 0; i < LATENCY; i++) begin
                lidx_q[i] <= lidx_d[i];
                lexp_q[i] <= lexp_d[i];
            end
        end
    end

endmodule

// File: tb/tb_arith_driver_0.sv
// tb/tb_arith_driver_0.sv - bench for arith_driver_0 at LATENCY 1 and 3 side by side
// An adder model with selectable corruption feeds each instance; a queue holds the expected operand pairs.
module tb_arith_driver_0;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_i;
    logic [7:0] count_i, seed_i;
    logic [8:0] res1, res3;
    logic [7:0] a1, b1, a3, b3, err1, err3, first1, first3;
    logic       busy1, busy3, done1, done3;

    int checks = 0;
    int errors = 0;
    int mode   = 0;
    int cidx   = 0;
    int mi1    = 0;
    int mi3    = 0;
    logic [8:0]  p1;
    logic [8:0]  p3 [3];
    logic [15:0] sbq [$];

    always #5 clk = ~clk;

    arith_driver_0 #(.LATENCY(1)) dut1 (
        .system1000(clk), .system1000_rst(rst), .start_i(start_i), .count_i(count_i),
        .seed_i(seed_i), .result_i(res1), .op_a_o(a1), .op_b_o(b1), .busy_o(busy1),
        .done_o(done1), .err_count_o(err1), .first_err_o(first1)
    );

    arith_driver_0 #(.LATENCY(3)) dut3 (
        .system1000(clk), .system1000_rst(rst), .start_i(start_i), .count_i(count_i),
        .seed_i(seed_i), .result_i(res3), .op_a_o(a3), .op_b_o(b3), .busy_o(busy3),
        .done_o(done3), .err_count_o(err3), .first_err_o(first3)
    );

    function automatic logic [8:0] sum9(input logic [7:0] a, input logic [7:0] b);
        return {a[7], a} + {b[7], b};
    endfunction

    function automatic logic [8:0] mdl(input logic [7:0] a, input logic [7:0] b,
                                       input int idx, input int md, input int ci);
        logic [8:0] s;
        s = sum9(a, b);
        if (md == 1) return (idx == ci) ? (s ^ 9'h001) : s;
        if (md == 2) return 9'h000;
        return s;
    endfunction

    function automatic logic [15:0] lstep(input logic [15:0] l);
        logic [15:0] n;
        n = {1'b0, l[15:1]};
        if (l[0]) n = n ^ 16'hB400;
        return n;
    endfunction

    // External arithmetic block: LATENCY register stages, index tracked from issue cycles.
    always @(posedge clk) begin
        if (start_i && !busy1) mi1 <= 0; else if (busy1) mi1 <= mi1 + 1;
        if (start_i && !busy3) mi3 <= 0; else if (busy3) mi3 <= mi3 + 1;
        p1    <= mdl(a1, b1, mi1, mode, cidx);
        p3[0] <= mdl(a3, b3, mi3, mode, cidx);
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign res1 = p1;
    assign res3 = p3[2];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset();
        check("rst_op_a1", 32'(a1), 32'h0);     check("rst_op_b1", 32'(b1), 32'h0);
        check("rst_op_a3", 32'(a3), 32'h0);     check("rst_op_b3", 32'(b3), 32'h0);
        check("rst_busy1", 32'(busy1), 32'h0);  check("rst_busy3", 32'(busy3), 32'h0);
        check("rst_done1", 32'(done1), 32'h0);  check("rst_done3", 32'(done3), 32'h0);
        check("rst_err1", 32'(err1), 32'h0);    check("rst_err3", 32'(err3), 32'h0);
        check("rst_first1", 32'(first1), 32'hFF); check("rst_first3", 32'(first3), 32'hFF);
    endtask

    task automatic run(input logic [7:0] seed, input logic [7:0] cnt, input int md,
                       input int ci, input bit poke);
        logic [15:0] l;
        int e  = 0;
        int f  = 255;
        int d1 = 0;
        int d3 = 0;
        mode = md;
        cidx = ci;
        l = {seed, 8'hA5};
        for (int i = 0; i < int'(cnt); i++) begin
            sbq.push_back(l);
            if (mdl(l[7:0], l[15:8], i, md, ci) !== sum9(l[7:0], l[15:8])) begin
                if (e < 255) e++;
                if (f == 255) f = i;
            end
            l = lstep(l);
        end
        count_i = cnt;
        seed_i  = seed;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int i = 0; i < int'(cnt); i++) begin
            l = sbq.pop_front();
            check("op_a1", 32'(a1), 32'(l[7:0]));  check("op_b1", 32'(b1), 32'(l[15:8]));
            check("op_a3", 32'(a3), 32'(l[7:0]));  check("op_b3", 32'(b3), 32'(l[15:8]));
            check("busy1_run", 32'(busy1), 32'h1); check("busy3_run", 32'(busy3), 32'h1);
            if (poke && i == 1) begin
                start_i = 1'b1;
                seed_i  = ~seed;
                count_i = 8'd3;
            end
            tick();
            start_i = 1'b0;
        end
        for (int k = 0; k < 20; k++) begin
            if (done1 && done3) break;
            if (busy1) d1++;
            if (busy3) d3++;
            tick();
        end
        check("done1", 32'(done1), 32'h1);
        check("done3", 32'(done3), 32'h1);
        check("drain1_cycles", 32'(d1), (cnt == 8'd0) ? 32'd0 : 32'd1);
        check("drain3_cycles", 32'(d3), (cnt == 8'd0) ? 32'd0 : 32'd3);
        check("err1", 32'(err1), 32'(e));       check("err3", 32'(err3), 32'(e));
        check("first1", 32'(first1), 32'(f));   check("first3", 32'(first3), 32'(f));
        repeat (3) tick();
        check("hold_err1", 32'(err1), 32'(e));  check("hold_first3", 32'(first3), 32'(f));
        check("hold_done1", 32'(done1), 32'h1); check("hold_busy3", 32'(busy3), 32'h0);
    endtask

    initial begin
        int bs, bi, bsum, v;
        logic [15:0] l;

        rst = 1'b1; start_i = 1'b0; count_i = 8'h00; seed_i = 8'h00;
        #1;
        check_reset();
        tick(); tick();
        rst = 1'b0;
        tick();

        run(8'h00, 8'd4, 0, 0, 1'b0);
        run(8'h5A, 8'd8, 1, 2, 1'b0);
        run(8'hC3, 8'd255, 2, 0, 1'b0);
        run(8'h12, 8'd0, 0, 0, 1'b0);
        run(8'h77, 8'd6, 0, 0, 1'b1);

        // Reset in the middle of DRAIN of the LATENCY-3 instance, then a fresh run.
        mode = 1; cidx = 0;
        count_i = 8'd6; seed_i = 8'h9E; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (7) tick();
        check("pre_rst_busy3", 32'(busy3), 32'h1);
        check("pre_rst_err3", 32'(err3), 32'h1);
        #2 rst = 1'b1;
        #1;
        check_reset();
        tick();
        rst = 1'b0;
        run(8'h3C, 8'd6, 0, 0, 1'b0);

        // Most negative operand pair reachable (op_a = op_b = 8'h80 when it exists).
        bs = 0; bi = 0; bsum = 1000;
        for (int s = 0; s < 256; s++) begin
            l = {8'(s), 8'hA5};
            for (int i = 0; i < 255; i++) begin
                v = int'(signed'(l[7:0])) + int'(signed'(l[15:8]));
                if (v < bsum) begin
                    bsum = v; bs = s; bi = i;
                end
                l = lstep(l);
            end
        end
        run(8'(bs), 8'(bi + 1), 0, 0, 1'b0);
        run(8'(bs), 8'(bi + 1), 1, bi, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
